cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

CPU clock-enable controller for the board-level RISC-V top, replacing the single free-toggling divided clock. It generates a one-cycle `cpu_en` strobe for the CPU and supports four modes: free-run with a programmable divider, single-step from a debounced push-button, halt, and an optional PC breakpoint. It sits between the board inputs (switches and button) and the `cpu` instance. Its status outputs feed SEG/LED and the LCD debug bus.

## Interface
- `NBITS`, 8, PC/address width (matches CPU `NBITS`)
- `DIV_BITS`, 4, width of divider setting
- `NSYNC`, 2, synchronizer stages on `step_btn` (≥2)
- `CYCLE_BITS`, 16, width of issued-enable counter
- `clk_2` in 1: board clock; one clock domain, all logic on its rising edge
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets the block
- `run` in 1: level; 1 = free-run requested, 0 = halt requested
- `step_btn` in 1: asynchronous push-button, active-high
- `div` in DIV_BITS: enable period is `div+1` cycles in RUN
- `pc` in NBITS: current CPU PC
- `bp_addr` in NBITS: breakpoint address
- `bp_valid` in 1: breakpoint enable
- `cpu_en` out 1: registered one-cycle CPU advance strobe
- `cpu_clk_vis` out 1: toggles once per issued `cpu_en` (drives SEG[7])
- `halted` out 1: 1 in HALT or BREAK
- `bp_hit` out 1: sticky breakpoint flag
- `cycle_count` out CYCLE_BITS: number of `cpu_en` strobes issued, wraps

## Operation
- Reset values: state HALT, `cpu_en`=0, `cpu_clk_vis`=0, `halted`=1, `bp_hit`=0, `cycle_count`=0, divider count 0, bp armed=1, synchronizer flops 0.
- `step_btn` passes through NSYNC flops and then a rising-edge detector, producing `step_pulse` (one cycle).
- HALT: no enables. If `run`=1, go to RUN and clear the divider count. Otherwise, if `step_pulse`, assert `cpu_en` and go to STEP. When both occur, `run` wins and the step is dropped.
- STEP: `cpu_en` is high for exactly this one cycle. Next state is HALT. `step_pulse` is ignored.
- RUN: the divider count runs 0..`div`. At terminal (`count >= div`), an enable is due and the count returns to 0. A due enable is issued unless a break condition holds. `run`=0 returns to HALT at the next edge and no further enables are issued. `step_pulse` is ignored.
- Break condition: armed && `bp_valid` && `pc == bp_addr` at the edge where an enable is due. When it holds: no enable is issued, the state goes to BREAK, `bp_hit` is set to 1, and armed is cleared.
- BREAK: no enables. `step_pulse` issues one enable and goes to STEP. `run`=0 goes to HALT.
- Armed is set on every issued `cpu_en`. This lets resume or step proceed past the breakpoint PC.
- `bp_hit` is cleared on every issued `cpu_en`.
- `cycle_count` increments modulo 2^CYCLE_BITS on each issued enable.
- `cpu_clk_vis` toggles at the edge after each `cpu_en` high.
- `div` changed mid-count: the `>=` compare makes a count above the new `div` terminate immediately.

## Timing
- `run` sampled 1 at edge k: state is RUN from edge k. The first `cpu_en` is high after edge k+`div`+1, then once every `div`+1 cycles. With `div`=0, `cpu_en` is continuously high from edge k+1.
- Button rise settled before edge k: `step_pulse` is high after edge k+NSYNC, and `cpu_en` is high after edge k+NSYNC+1, for one cycle.
- `run` falling at edge k: no `cpu_en` is high after edge k. `halted`=1 after edge k.
- Breakpoint: `cpu_en` stays 0 in the cycle it would have been due. `bp_hit`, `halted` and BREAK are all visible after that same edge.
- `reset`=0 at any edge: all outputs take their reset values after that edge, including an in-flight `cpu_en`.

## Configuration
- `CPU_BREAKPOINT_EN` defined: breakpoint logic present as described.
- `CPU_BREAKPOINT_EN` undefined: `bp_addr` and `bp_valid` ports remain but are ignored. BREAK is unreachable, `bp_hit` is tied 0, and there is no comparator or armed flop.

## Structure
- Package `cpu_ctrl_pkg`: `typedef enum logic [1:0] {HALT, RUN, STEP, BREAK} ctrl_state_t`, plus reset-value localparams.
- Sub-module `btn_sync_edge` (parameter NSYNC): synchronizer plus rising-edge detector producing `step_pulse`.

## Test plan
- Reset held 0 for 3 cycles with `run`=1 → `cpu_en`=0, `halted`=1, `cycle_count`=0 throughout.
- `run`=1, `div`=3 for 20 cycles → `cpu_en` pulses at cycles 4, 8, 12, 16, 20; `cycle_count`=5; `cpu_clk_vis` toggled 5 times.
- `run`=0, NSYNC=2, `step_btn` held high for 10 cycles → exactly one `cpu_en` at cycle 3 after the rise; `cycle_count`=1.
- `run`=1 and `step_pulse` in the same HALT cycle → RUN entered, no STEP, no extra enable.
- Define `CPU_BREAKPOINT_EN`. Set `bp_valid`=1, `bp_addr`=8'h0C, `div`=0, and drive `pc` to increment by 4 per enable from 0 → exactly 3 enables, then BREAK with `bp_hit`=1. `run`=0 then 1 → enables resume and `bp_hit`=0 after the first one.
- `div`=15 mid-count at count=10, then `div`=2 → enable on the next cycle, then period 3. Also: with `CYCLE_BITS`=4, 17 enables → `cycle_count`=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and reset values for the CPU clock-enable controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {HALT, RUN, STEP, BREAK} ctrl_state_t;

  localparam ctrl_state_t RST_STATE   = HALT;
  localparam logic        RST_CPU_EN  = 1'b0;
  localparam logic        RST_CLK_VIS = 1'b0;
  localparam logic        RST_BP_HIT  = 1'b0;
  localparam logic        RST_ARMED   = 1'b1;
  localparam logic        RST_SYNC    = 1'b0;

endpackage

// File: rtl/cpu_clk_ctrl_btn_sync_edge.sv
// Push-button synchronizer followed by a registered rising-edge detector;
// step_pulse is high for one cycle, NSYNC edges after the button rise is sampled.
module btn_sync_edge
  import cpu_ctrl_pkg::*;
#(
  parameter int NSYNC = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic btn,
  output logic step_pulse
);

  logic [NSYNC-1:0] sync_q, sync_d;
  logic             prev_q, prev_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[NSYNC-2:0], btn};
    prev_d  = sync_q[NSYNC-1];
    pulse_d = sync_q[NSYNC-1] & ~prev_q;
  end

  always_ff @(posedge clk_2) begin
    if (!reset) begin
      sync_q  <= {NSYNC{RST_SYNC}};
      prev_q  <= RST_SYNC;
      pulse_q <= RST_SYNC;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: HALT / RUN (divided) / STEP (button) / BREAK (PC match).
// Breakpoint logic is built only when CPU_BREAKPOINT_EN is defined.
module cpu_clk_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int DIV_BITS   = 4,
  parameter int NSYNC      = 2,
  parameter int CYCLE_BITS = 16
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step_btn,
  input  logic [DIV_BITS-1:0]   div,
  input  logic [NBITS-1:0]      pc,
  input  logic [NBITS-1:0]      bp_addr,
  input  logic                  bp_valid,
  output logic                  cpu_en,
  output logic                  cpu_clk_vis,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [CYCLE_BITS-1:0] cycle_count
);

  ctrl_state_t           state_q, state_d;
  logic [DIV_BITS-1:0]   cnt_q, cnt_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  vis_q, vis_d;
  logic [CYCLE_BITS-1:0] cycles_q, cycles_d;
  logic                  step_pulse, due, bp_match, issue;

  btn_sync_edge #(.NSYNC(NSYNC)) u_btn_sync (
    .clk_2      (clk_2),
    .reset      (reset),
    .btn        (step_btn),
    .step_pulse (step_pulse)
  );

`ifdef CPU_BREAKPOINT_EN
  logic armed_q, armed_d;
  logic bp_hit_q, bp_hit_d;

  assign bp_match = armed_q && bp_valid && (pc == bp_addr);

  // An issued enable re-arms so resume/step can move past the breakpoint PC.
  always_comb begin
    armed_d  = armed_q;
    bp_hit_d = bp_hit_q;
    if (issue) begin
      armed_d  = 1'b1;
      bp_hit_d = 1'b0;
    end else if (due && bp_match) begin
      armed_d  = 1'b0;
      bp_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset) begin
      armed_q  <= RST_ARMED;
      bp_hit_q <= RST_BP_HIT;
    end else begin
      armed_q  <= armed_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc, bp_addr, bp_valid};
  assign bp_match         = 1'b0;
  assign bp_hit           = RST_BP_HIT;
`endif

  // The >= compare lets a lowered div terminate an over-range count at once.
  assign due = (state_q == RUN) && run && (cnt_q >= div);

  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      cpu_en_q <= RST_CPU_EN;
      vis_q    <= RST_CLK_VIS;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpu_en_q <= cpu_en_d;
      vis_q    <= vis_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT:    if (run) state_d = RUN;
               else if (step_pulse) state_d = STEP;
      STEP:    state_d = HALT;
      RUN:     if (!run) state_d = HALT;
               else if (due && bp_match) state_d = BREAK;
      BREAK:   if (step_pulse) state_d = STEP;
               else if (!run) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    issue    = (state_d == STEP) || (due && !bp_match);
    cpu_en_d = issue;
    vis_d    = vis_q ^ cpu_en_q;
    cycles_d = cycles_q + CYCLE_BITS'(issue);
    cnt_d    = cnt_q;
    if (state_q == HALT && run) begin
      cnt_d = '0;
    end else if (state_q == RUN && run) begin
      cnt_d = (cnt_q >= div) ? '0 : cnt_q + 1'b1;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign cpu_clk_vis = vis_q;
  assign halted      = (state_q == HALT) || (state_q == BREAK);
  assign cycle_count = cycles_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: per-cycle behavioural model plus directed scenarios.
// Works with or without CPU_BREAKPOINT_EN defined.
module tb_cpu_clk_ctrl;

  localparam int NBITS      = 8;
  localparam int DIV_BITS   = 4;
  localparam int NSYNC      = 2;
  localparam int CYCLE_BITS = 4;
`ifdef CPU_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic                  clk_2 = 1'b0;
  logic                  reset = 1'b0;
  logic                  run = 1'b0;
  logic                  step_btn = 1'b0;
  logic [DIV_BITS-1:0]   div = '0;
  logic [NBITS-1:0]      pc = '0;
  logic [NBITS-1:0]      bp_addr = '0;
  logic                  bp_valid = 1'b0;
  logic                  cpu_en, cpu_clk_vis, halted, bp_hit;
  logic [CYCLE_BITS-1:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit pc_follow = 1'b0;

  always #5 clk_2 = ~clk_2;

  cpu_clk_ctrl #(
    .NBITS(NBITS), .DIV_BITS(DIV_BITS), .NSYNC(NSYNC), .CYCLE_BITS(CYCLE_BITS)
  ) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .run         (run),
    .step_btn    (step_btn),
    .div         (div),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .cpu_en      (cpu_en),
    .cpu_clk_vis (cpu_clk_vis),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: predicts the outputs after every rising edge.
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BRK = 3;
  initial begin : model
    int mode, cnt, cycles;
    bit en, vis, hit, armed, pulse, issue;
    bit hist [NSYNC+2];
    mode = M_HALT; cnt = 0; cycles = 0;
    en = 0; vis = 0; hit = 0; armed = 1;
    for (int i = 0; i < NSYNC + 2; i++) hist[i] = 1'b0;
    forever begin
      @(posedge clk_2);
      if (!reset) begin
        mode = M_HALT; cnt = 0; cycles = 0;
        en = 0; vis = 0; hit = 0; armed = 1;
        for (int i = 0; i < NSYNC + 2; i++) hist[i] = 1'b0;
      end else begin
        // hist[i] holds the button as sampled i+1 edges ago.
        pulse = hist[NSYNC] && !hist[NSYNC+1];
        for (int i = NSYNC + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = step_btn;
        issue = 1'b0;
        case (mode)
          M_HALT: begin
            if (run) begin mode = M_RUN; cnt = 0; end
            else if (pulse) begin issue = 1'b1; mode = M_STEP; end
          end
          M_STEP: mode = M_HALT;
          M_RUN: begin
            if (!run) mode = M_HALT;
            else if (cnt >= int'(div)) begin
              cnt = 0;
              if (BP_ON && armed && bp_valid && pc == bp_addr) begin
                mode = M_BRK; hit = 1'b1; armed = 1'b0;
              end else issue = 1'b1;
            end else cnt = cnt + 1;
          end
          default: begin
            if (pulse) begin issue = 1'b1; mode = M_STEP; end
            else if (!run) mode = M_HALT;
          end
        endcase
        vis = vis ^ en;
        en  = issue;
        if (issue) begin
          cycles = (cycles + 1) % (1 << CYCLE_BITS);
          hit = 1'b0;
          armed = 1'b1;
        end
      end
      #1;
      check("model cpu_en", cpu_en, en);
      check("model cpu_clk_vis", cpu_clk_vis, vis);
      check("model halted", halted, (mode == M_HALT || mode == M_BRK));
      check("model bp_hit", bp_hit, hit);
      check("model cycle_count", cycle_count, cycles);
    end
  end

  // One clock: observe just after the edge, then return at the falling edge
  // where the caller may change inputs. The CPU PC advances on each enable.
  task automatic cyc(output logic en_o);
    @(posedge clk_2);
    #1;
    en_o = cpu_en;
    @(negedge clk_2);
    if (pc_follow && cpu_en) pc = pc + 8'd4;
  endtask

  task automatic rst_pulse();
    logic e;
    reset = 1'b0; run = 1'b0; step_btn = 1'b0; div = '0;
    cyc(e);
    reset = 1'b1;
  endtask

  initial begin : stim
    logic e;
    logic [31:0] mask;
    int n, toggles;
    logic vis_prev;

    // Reset held with run requested.
    reset = 1'b0; run = 1'b1; div = 4'd3;
    for (int i = 0; i < 3; i++) begin
      cyc(e);
      check("reset cpu_en", e, 0);
      check("reset halted", halted, 1);
      check("reset cycle_count", cycle_count, 0);
    end

    // Free-run, div=3: enables at 4,8,12,16,20 edges after run is seen.
    reset = 1'b1;
    mask = 0; toggles = 0; vis_prev = cpu_clk_vis;
    for (int i = 0; i < 22; i++) begin
      cyc(e);
      if (e) mask = mask | (32'd1 << i);
      if (cpu_clk_vis != vis_prev) toggles++;
      vis_prev = cpu_clk_vis;
    end
    check("run div3 enable pattern", mask, 32'h0011_1110);
    check("run div3 cycle_count", cycle_count, 5);
    check("run div3 vis toggles", toggles, 5);

    // Single step: button held high, one enable NSYNC+1 edges later.
    rst_pulse();
    step_btn = 1'b1;
    mask = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(e);
      if (e) mask = mask | (32'd1 << i);
    end
    check("step enable pattern", mask, 32'h0000_0008);
    check("step cycle_count", cycle_count, 1);
    step_btn = 1'b0;

    // run and step_pulse in the same HALT cycle: run wins.
    rst_pulse();
    div = 4'd5;
    step_btn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(e);
    run = 1'b1;
    mask = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(e);
      if (e) mask = mask | (32'd1 << i);
      if (i == 0) check("run-vs-step halted", halted, 0);
    end
    check("run-vs-step enable pattern", mask, 32'h0000_0040);
    step_btn = 1'b0;

    // Breakpoint at PC 0x0C with the PC advancing by 4 per enable.
    rst_pulse();
    pc = '0; pc_follow = 1'b1; bp_valid = 1'b1; bp_addr = 8'h0C; div = 4'd0; run = 1'b1;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(e);
      if (e) n++;
    end
`ifdef CPU_BREAKPOINT_EN
    check("bp enables before break", n, 3);
    check("bp bp_hit", bp_hit, 1);
    check("bp halted", halted, 1);
    check("bp cycle_count", cycle_count, 3);
    check("bp pc", pc, 8'h0C);
`else
    check("no-bp enables", n, 8);
    check("no-bp bp_hit", bp_hit, 0);
`endif
    run = 1'b0;
    cyc(e);
    check("bp halt halted", halted, 1);
    run = 1'b1;
    cyc(e);
    check("resume first edge cpu_en", e, 0);
    cyc(e);
    check("resume cpu_en", e, 1);
    check("resume bp_hit", bp_hit, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(e);
      check("resume continues", e, 1);
    end
    pc_follow = 1'b0; bp_valid = 1'b0; run = 1'b0;

    // div lowered from 15 to 2 while the count is at 10.
    rst_pulse();
    div = 4'd15; run = 1'b1;
    mask = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(e);
      if (e) mask = mask | (32'd1 << i);
      if (i == 10) div = 4'd2;
    end
    check("div change enable pattern", mask, 32'h0002_4800);

    // 17 enables wrap a 4-bit counter to 1; then stop and reset in flight.
    rst_pulse();
    div = 4'd0; run = 1'b1;
    n = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(e);
      if (e) n++;
    end
    check("wrap enables", n, 17);
    check("wrap cycle_count", cycle_count, 1);
    run = 1'b0;
    cyc(e);
    check("run fall cpu_en", e, 0);
    check("run fall halted", halted, 1);
    run = 1'b1;
    cyc(e);
    cyc(e);
    check("pre-reset cpu_en", e, 1);
    reset = 1'b0;
    cyc(e);
    check("reset in flight cpu_en", e, 0);
    check("reset in flight cycle_count", cycle_count, 0);
    check("reset in flight vis", cpu_clk_vis, 0);
    check("reset in flight halted", halted, 1);
    reset = 1'b1; run = 1'b0;
    cyc(e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d compared, expected completion", n_cmp);
    $fatal(1, "time limit reached");
  end

endmodule
